rf_writeback_ctrl: RTL and testbench
====================================

# rf_writeback_ctrl

Writeback controller driving the write port of the single-cycle MIPS register file (RF_SCP write side: RFWE/RFWA/RFWD). It merges single-cycle ALU results with results from long-latency units (loads, multiply/divide) that arrive over a valid/ready handshake. Long-latency results are buffered in a small FIFO. The block enforces $0 immutability and resolves write-after-write ordering by squashing stale queued writes. It also exports a pending-write mask so decode can stall on registers with queued writes.

## Interface
- WL, 32, data word length
- AL, 5, register address width (2**AL registers)
- DEPTH, 4, long-latency FIFO depth (power of 2, ≥2)

- CLK  in  1  clock; all state updates on posedge
- RST_N  in  1  asynchronous, active-low reset
- ALUWE  in  1  ALU result write request; always accepted
- ALUWA  in  AL  ALU destination register
- ALUWD  in  WL  ALU result
- LWVALID  in  1  long-latency result valid
- LWA  in  AL  long-latency destination register
- LWD  in  WL  long-latency result
- LWREADY  out  1  FIFO can accept; a transfer occurs when LWVALID && LWREADY
- RFWE  out  1  RF write enable (registered)
- RFWA  out  AL  RF write address (registered)
- RFWD  out  WL  RF write data (registered)
- PENDMASK  out  2**AL  bit r set when a valid FIFO entry targets register r

## Operation
- Each cycle, exactly one source is selected for the output register:
  - ALU, if ALUWE && ALUWA != 0 (highest priority);
  - else the FIFO head, if the FIFO is non-empty (the head is popped);
  - else nothing (RFWE=0 next cycle, RFWA/RFWD hold).
- $0 writes: ALU writes with ALUWA == 0 are dropped. LW transfers with LWA == 0 complete the handshake but are not enqueued. RFWE is never asserted with RFWA == 0.
- LWREADY = (count < DEPTH). It depends on state only and does not combinationally depend on LWVALID.
- WAW squash: an ALU write to register r is younger than any queued or same-cycle LW write to r.
  - Every valid FIFO entry with address r is invalidated in that cycle.
  - A same-cycle LW transfer to r is accepted but not enqueued.
- Invalidated entries keep their slot until they reach the head. At the head they are popped without asserting RFWE, and that pop consumes that cycle's FIFO turn.
- Push and pop in the same cycle are both honoured; count is unchanged.
- PENDMASK is the OR of one-hot(addr) over valid entries. It is updated from registered state with no combinational path from inputs.
- Arithmetic: read/write pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.

## Timing
- Latency: an accepted input appears on RFWE/RFWA/RFWD exactly 1 cycle later if selected. An LW entry appears at least 1 cycle after its push; the FIFO adds latency while the ALU holds priority.
- The RF samples the write on the following posedge, so data is architecturally visible 2 edges after input.
- Reset (async assert, sync-safe deassert):
  - RFWE=0, RFWA=0, RFWD=0;
  - FIFO empty, all entry valid bits 0, pointers 0;
  - PENDMASK=0, LWREADY=1.
- Reset mid-operation discards all queued writes. There is no partial write: RFWE drops immediately on RST_N assertion.
- Full FIFO with continuous ALU traffic: LWREADY stays 0, and LWVALID must hold its data until accepted (standard valid/ready; the producer must not drop valid).
- Full FIFO and pop in the same cycle: LWREADY was already 0 that cycle, so no push occurs. LWREADY rises the next cycle.

## Structure
- Shared package: WL/AL defaults, REG_ZERO constant (0), and a write-request struct/typedef {valid, addr, data} used by the FIFO entries and output stage.
- One sub-module: wb_fifo. It holds DEPTH entries with per-entry valid, the squash-by-address port, count, and PENDMASK generation.
- The top level contains the priority selector and the output register.

## Test plan
- Reset, then ALUWE=1, ALUWA=8, ALUWD=0x0000_00AA -> next cycle RFWE=1, RFWA=8, RFWD=0xAA. With ALUWE=0 the following cycle, RFWE=0.
- Write to zero: ALUWA=0, then LW push with LWA=0 -> RFWE never 1, PENDMASK stays 0, LWREADY stays 1.
- Fill: 4 LW pushes (regs 9..12) while ALUWE=1 every cycle (reg 16) -> LWREADY=0 after the 4th push, PENDMASK=0x0000_1E00. Then ALUWE=0 -> RF writes 9,10,11,12 in order on 4 consecutive cycles.
- WAW squash: LW push reg 10 = 0x1111, then ALU write reg 10 = 0x2222 while the FIFO is blocked -> PENDMASK bit 10 clears, and reg 10 is written only with 0x2222.
- Same-cycle conflict: LWVALID with LWA=5 and ALUWE with ALUWA=5 in one cycle -> handshake completes, exactly one RF write (ALU data), PENDMASK bit 5 never set.
- Reset with 3 entries queued -> RFWE=0 immediately, PENDMASK=0, LWREADY=1. No queued data is written after RST_N deasserts.

Source files
------------

// File: rtl/rf_writeback_ctrl_pkg.sv
// Shared types and constants for the register-file writeback controller.
package rf_writeback_ctrl_pkg;

  localparam int unsigned WL    = 32;
  localparam int unsigned AL    = 5;
  localparam int unsigned NREGS = 1 << AL;

  localparam logic [AL-1:0] REG_ZERO = '0;

  // One register-file write request; used by FIFO entries and the output stage.
  typedef struct packed {
    logic          valid;
    logic [AL-1:0] addr;
    logic [WL-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/rf_writeback_ctrl_if.sv
// Writeback bus: ALU write request, long-latency valid/ready channel and RF write port.
interface rf_writeback_ctrl_if;
  import rf_writeback_ctrl_pkg::*;

  logic             aluwe;
  logic [AL-1:0]    aluwa;
  logic [WL-1:0]    aluwd;
  logic             lwvalid;
  logic [AL-1:0]    lwa;
  logic [WL-1:0]    lwd;
  logic             lwready;
  logic             rfwe;
  logic [AL-1:0]    rfwa;
  logic [WL-1:0]    rfwd;
  logic [NREGS-1:0] pendmask;

  modport master (
    output aluwe, aluwa, aluwd, lwvalid, lwa, lwd,
    input  lwready, rfwe, rfwa, rfwd, pendmask
  );

  modport slave (
    input  aluwe, aluwa, aluwd, lwvalid, lwa, lwd,
    output lwready, rfwe, rfwa, rfwd, pendmask
  );

endinterface

// File: rtl/rf_writeback_ctrl_wb_fifo.sv
// Long-latency result FIFO with per-entry valid, squash-by-address and pending mask.
module wb_fifo
  import rf_writeback_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [AL-1:0]    i_push_addr,
  input  logic [WL-1:0]    i_push_data,
  input  logic             i_pop,
  input  logic             i_squash,
  input  logic [AL-1:0]    i_squash_addr,
  output wr_req_t          o_head,
  output logic             o_empty,
  output logic             o_ready,
  output logic [NREGS-1:0] o_pendmask
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  wr_req_t           r_mem [DEPTH];
  logic [PtrW-1:0]   r_wptr;
  logic [PtrW-1:0]   r_rptr;
  logic [CntW-1:0]   r_count;

  assign o_head  = r_mem[r_rptr];
  assign o_empty = (r_count == '0);
  assign o_ready = (r_count < CntW'(DEPTH));

  // Entry storage, pointers and occupancy; squashed entries keep their slot.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (i_squash && r_mem[i].valid && (r_mem[i].addr == i_squash_addr)) begin
          r_mem[i].valid <= 1'b0;
        end
      end
      // Clear on pop so a retired slot never contributes to the pending mask.
      if (i_pop) begin
        r_mem[r_rptr].valid <= 1'b0;
        r_rptr              <= r_rptr + PtrW'(1);
      end
      if (i_push) begin
        r_mem[r_wptr] <= '{valid: 1'b1, addr: i_push_addr, data: i_push_data};
        r_wptr        <= r_wptr + PtrW'(1);
      end
      unique case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Pending mask: one-hot of every still-valid entry's destination.
  always_comb begin
    o_pendmask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_mem[i].valid) o_pendmask[r_mem[i].addr] = 1'b1;
    end
  end

endmodule

// File: rtl/rf_writeback_ctrl.sv
// Writeback controller: ALU-priority merge of long-latency results into the RF write port.
module rf_writeback_ctrl
  import rf_writeback_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  rf_writeback_ctrl_if.slave   io_wb
);

  logic             w_alu_sel;
  logic             w_pop;
  logic             w_push;
  logic             w_empty;
  logic             w_ready;
  wr_req_t          w_head;
  logic [NREGS-1:0] w_pendmask;
  wr_req_t          r_out;

  assign w_alu_sel = io_wb.aluwe && (io_wb.aluwa != REG_ZERO);
  assign w_pop     = !w_alu_sel && !w_empty;
  // An accepted LW is dropped if it targets $0 or is overtaken by a same-cycle ALU write.
  assign w_push    = io_wb.lwvalid && w_ready && (io_wb.lwa != REG_ZERO) &&
                     !(w_alu_sel && (io_wb.lwa == io_wb.aluwa));

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_push        (w_push),
    .i_push_addr   (io_wb.lwa),
    .i_push_data   (io_wb.lwd),
    .i_pop         (w_pop),
    .i_squash      (w_alu_sel),
    .i_squash_addr (io_wb.aluwa),
    .o_head        (w_head),
    .o_empty       (w_empty),
    .o_ready       (w_ready),
    .o_pendmask    (w_pendmask)
  );

  // Output register: ALU first, then FIFO head; a squashed head pops without writing.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_out <= '0;
    end else if (w_alu_sel) begin
      r_out <= '{valid: 1'b1, addr: io_wb.aluwa, data: io_wb.aluwd};
    end else if (w_pop && w_head.valid) begin
      r_out <= w_head;
    end else begin
      r_out.valid <= 1'b0;
    end
  end

  assign io_wb.rfwe     = r_out.valid;
  assign io_wb.rfwa     = r_out.addr;
  assign io_wb.rfwd     = r_out.data;
  assign io_wb.lwready  = w_ready;
  assign io_wb.pendmask = w_pendmask;

endmodule

// File: tb/tb_rf_writeback_ctrl.sv
// Bench for rf_writeback_ctrl: directed vector table, reset corner case, random vs queue model.
module tb_rf_writeback_ctrl;
  import rf_writeback_ctrl_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  rf_writeback_ctrl_if u_if ();

  rf_writeback_ctrl #(
    .DEPTH (DEPTH)
  ) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_wb   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        aluwe;
    logic [4:0]  aluwa;
    logic [31:0] aluwd;
    logic        lwvalid;
    logic [4:0]  lwa;
    logic [31:0] lwd;
    logic        e_we;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_rdy;
    logic [31:0] e_pm;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  // Reference model: an ordered queue of pending writes.
  typedef struct {
    bit          v;
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;
  logic        m_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic awe, input logic [4:0] awa, input logic [31:0] awd,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld);
    u_if.aluwe   = awe;
    u_if.aluwa   = awa;
    u_if.aluwd   = awd;
    u_if.lwvalid = lv;
    u_if.lwa     = la;
    u_if.lwd     = ld;
  endtask

  task automatic check_all(input string tag, input logic we, input logic [4:0] wa,
                           input logic [31:0] wd, input logic rdy, input logic [31:0] pm);
    check($sformatf("%s rfwe", tag), 32'(u_if.rfwe), 32'(we));
    check($sformatf("%s rfwa", tag), 32'(u_if.rfwa), 32'(wa));
    check($sformatf("%s rfwd", tag), u_if.rfwd, wd);
    check($sformatf("%s lwready", tag), 32'(u_if.lwready), 32'(rdy));
    check($sformatf("%s pendmask", tag), u_if.pendmask, pm);
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit alu_sel;
    ent_t h;
    m_acc   = u_if.lwvalid && (q.size() < DEPTH);
    alu_sel = u_if.aluwe && (u_if.aluwa != 5'd0);
    if (alu_sel) begin
      foreach (q[i]) if (q[i].a == u_if.aluwa) q[i].v = 1'b0;
      m_we = 1'b1;
      m_wa = u_if.aluwa;
      m_wd = u_if.aluwd;
    end else if (q.size() > 0) begin
      h    = q.pop_front();
      m_we = h.v;
      if (h.v) begin
        m_wa = h.a;
        m_wd = h.d;
      end
    end else begin
      m_we = 1'b0;
    end
    if (m_acc && (u_if.lwa != 5'd0) && !(alu_sel && (u_if.lwa == u_if.aluwa))) begin
      q.push_back('{v: 1'b1, a: u_if.lwa, d: u_if.lwd});
    end
  endtask

  function automatic logic [31:0] model_pm();
    logic [31:0] pm;
    pm = '0;
    foreach (q[i]) if (q[i].v) pm[q[i].a] = 1'b1;
    return pm;
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;

    //            awe awa  aluwd         lv  lwa  lwd           we wa  wd            rdy pm
    vecs[0]  = '{1, 8,  32'h0000_00AA, 0, 0,  32'h0,        1, 8,  32'h0000_00AA, 1, 32'h0};
    vecs[1]  = '{0, 0,  32'h0,         0, 0,  32'h0,        0, 8,  32'h0000_00AA, 1, 32'h0};
    vecs[2]  = '{1, 0,  32'h55,        0, 0,  32'h0,        0, 8,  32'h0000_00AA, 1, 32'h0};
    vecs[3]  = '{0, 0,  32'h0,         1, 0,  32'h77,       0, 8,  32'h0000_00AA, 1, 32'h0};
    vecs[4]  = '{1, 16, 32'h100,       1, 9,  32'h900,      1, 16, 32'h100,       1, 32'h0200};
    vecs[5]  = '{1, 16, 32'h101,       1, 10, 32'hA00,      1, 16, 32'h101,       1, 32'h0600};
    vecs[6]  = '{1, 16, 32'h102,       1, 11, 32'hB00,      1, 16, 32'h102,       1, 32'h0E00};
    vecs[7]  = '{1, 16, 32'h103,       1, 12, 32'hC00,      1, 16, 32'h103,       0, 32'h1E00};
    vecs[8]  = '{1, 16, 32'h104,       1, 13, 32'hD00,      1, 16, 32'h104,       0, 32'h1E00};
    vecs[9]  = '{0, 0,  32'h0,         1, 13, 32'hD00,      1, 9,  32'h900,       1, 32'h1C00};
    vecs[10] = '{0, 0,  32'h0,         1, 13, 32'hD00,      1, 10, 32'hA00,       1, 32'h3800};
    vecs[11] = '{0, 0,  32'h0,         0, 0,  32'h0,        1, 11, 32'hB00,       1, 32'h3000};
    vecs[12] = '{0, 0,  32'h0,         0, 0,  32'h0,        1, 12, 32'hC00,       1, 32'h2000};
    vecs[13] = '{0, 0,  32'h0,         0, 0,  32'h0,        1, 13, 32'hD00,       1, 32'h0};
    vecs[14] = '{0, 0,  32'h0,         0, 0,  32'h0,        0, 13, 32'hD00,       1, 32'h0};
    vecs[15] = '{1, 16, 32'h200,       1, 10, 32'h1111,     1, 16, 32'h200,       1, 32'h0400};
    vecs[16] = '{1, 10, 32'h2222,      0, 0,  32'h0,        1, 10, 32'h2222,      1, 32'h0};
    vecs[17] = '{0, 0,  32'h0,         0, 0,  32'h0,        0, 10, 32'h2222,      1, 32'h0};
    vecs[18] = '{0, 0,  32'h0,         0, 0,  32'h0,        0, 10, 32'h2222,      1, 32'h0};
    vecs[19] = '{1, 5,  32'h5555,      1, 5,  32'h5AAA,     1, 5,  32'h5555,      1, 32'h0};
    vecs[20] = '{0, 0,  32'h0,         0, 0,  32'h0,        0, 5,  32'h5555,      1, 32'h0};

    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #12 rst_n = 1'b1;
    @(posedge clk); #1;
    check_all("reset", 1'b0, 5'd0, 32'h0, 1'b1, 32'h0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].aluwe, vecs[i].aluwa, vecs[i].aluwd, vecs[i].lwvalid, vecs[i].lwa,
            vecs[i].lwd);
      @(posedge clk); #1;
      check_all($sformatf("row%0d", i), vecs[i].e_we, vecs[i].e_wa, vecs[i].e_wd,
                vecs[i].e_rdy, vecs[i].e_pm);
    end

    // Queue three LW writes behind ALU traffic, then reset mid-cycle.
    for (int k = 0; k < 3; k++) begin
      drive(1, 16, 32'h300 + 32'(k), 1, 5'(k + 1), 32'h400 + 32'(k));
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0, 0);
    check("prereset pendmask", u_if.pendmask, 32'h0000_000E);
    check("prereset rfwe", 32'(u_if.rfwe), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_all("midreset", 1'b0, 5'd0, 32'h0, 1'b1, 32'h0);
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check_all($sformatf("postreset%0d", k), 1'b0, 5'd0, 32'h0, 1'b1, 32'h0);
    end

    // Random traffic against the queue model.
    q.delete();
    m_we  = 1'b0;
    m_wa  = '0;
    m_wd  = '0;
    m_acc = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      // A valid LW that was not accepted must be held unchanged.
      if (!(u_if.lwvalid && !m_acc)) begin
        u_if.lwvalid = ($urandom_range(99, 0) < 55);
        u_if.lwa     = 5'($urandom_range(7, 0));
        u_if.lwd     = $urandom;
      end
      u_if.aluwe = ($urandom_range(99, 0) < 45);
      u_if.aluwa = 5'($urandom_range(7, 0));
      u_if.aluwd = $urandom;
      model_step();
      @(posedge clk); #1;
      check_all($sformatf("rnd%0d", c), m_we, m_wa, m_wd, (q.size() < DEPTH), model_pm());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
